uart_rx_fifo: RTL
=================

# uart_rx_fifo

Serial 8N1 receiver with a first-word-fall-through byte FIFO. It is the receive end of the UART link that the Z80 SoC drives on `tx`. It sits in the board-level test harness and in the host-bridge FPGA, sampling the SoC's serial output and presenting received bytes on a simple pop interface. It is also the receive path for future console peripherals on the Z80 bus.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `DW_CNT`, 5: width of `count`; must equal log2(DEPTH)+1.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `cfg_divider`  in  32  clocks per bit, for example `BOARD_FREQ/115200`. Valid range is 4 and up. Must be static while a frame is in progress.
- `rd`  in  1  pop request.
- `rd_data`  out  8  FIFO head byte; valid when `valid`=1.
- `valid`  out  1  FIFO not empty.
- `count`  out  DW_CNT  number of bytes stored.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `ferr`  out  1  sticky: framing error (stop bit sampled low).
- `clear`  in  1  clears `overflow` and `ferr`.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All logic uses `rx_s` only.
- Bit timer: a 32-bit down-counter reloaded from `cfg_divider`. A half-bit reload uses `cfg_divider>>1`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of `rx_s` (previous 1, current 0), load the half-bit count and go to START.
  - START: when the timer expires, sample `rx_s`. If 1 (false start), return to IDLE. If 0, load the full-bit count, set bit index 0 and go to DATA.
  - DATA: at each expiry, shift the sample into the shift register at bit[index], LSB first. After index 7, load the full-bit count and go to STOP.
  - STOP: at expiry, sample the stop bit. If 1, push the byte. If 0, behaviour depends on the configuration macro. Either way, return to IDLE. A new start edge is recognised from the next cycle on.
- FIFO push/pop rules:
  - A pop happens when `rd`=1 and `valid`=1. `rd` while empty is ignored.
  - Push when not full: byte stored.
  - Push when full with no pop in the same cycle: byte dropped and `overflow` set.
  - Push and pop in the same cycle: both take effect. `count` is unchanged and there is no overflow, even when full.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `count` is in the range 0..DEPTH.
- Sticky flags: `clear` zeroes both flags. If a set condition and `clear` occur in the same cycle, the set wins.
- Reset values: FSM=IDLE, pointers=0, `count`=0, `valid`=0, `overflow`=0, `ferr`=0, `rd_data`=0 (RAM contents are don't-care but must not be visible). Synchronizer flops reset to 1.
- Reset mid-frame aborts the frame and discards the partial byte. Any frame already in progress on `rx` resynchronises at the next falling edge.

## Timing
- Synchronizer latency: 2 cycles.
- Let D = `cfg_divider`. The push occurs at roughly 2 + D/2 + 9·D cycles after the `rx` start edge (±1 cycle).
- `valid` and `count` update on the cycle after the push.
- `rd_data` reflects the new head in the cycle after a pop (registered head read).
- Back-to-back frames with no idle bit between them are received without loss. Receive rate is bounded only by the line rate.

## Configuration
- Macro: `UART_RX_FRAMING_CHECK_EN`.
- Defined:
  - A low stop bit sets `ferr` and the byte is discarded (not pushed).
  - After a framing error the FSM waits for `rx_s`=1 before re-arming IDLE edge detection. This avoids false starts during a break condition.
- Undefined:
  - The stop-bit value is ignored and the byte is always pushed.
  - `ferr` is tied to 0 and the break-wait logic is removed.

## Test plan
- Single byte: D=16, send 0xA5 8N1 → one push with `rd_data`=0xA5, `count`=1, `valid`=1. Pulse `rd` → `count`=0, `valid`=0.
- Glitch: `rx` low for 4 cycles (D=16) → false start; FIFO stays empty and the FSM returns to IDLE.
- Fill and overflow: DEPTH=16, send bytes 0x00..0x10 (17 bytes) with no reads → `count`=16, `overflow`=1. Reading returns 0x00..0x0F in order; 0x10 is lost. `clear` drops `overflow` to 0.
- Full plus simultaneous pop: with the FIFO full, assert `rd` on the push cycle of a new byte → `count` stays 16, `overflow` stays 0, and the new byte is read last.
- Framing error: send 0x3C with the stop bit low, then `rx` high, then 0x55. With the macro defined: `ferr`=1 and only 0x55 is queued. With it undefined: 0x3C and 0x55 are both queued and `ferr`=0.
- Reset mid-frame: assert `reset` after the 4th data bit of 0xFF, then send 0x12 → only 0x12 is received; all outputs are at their reset values during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a first-word-fall-through byte FIFO with a registered head.
// Optional stop-bit framing check and break wait: define UART_RX_FRAMING_CHECK_EN.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DW_CNT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [31:0]       cfg_divider,
    input  logic              rd,
    output logic [7:0]        rd_data,
    output logic              valid,
    output logic [DW_CNT-1:0] count,
    output logic              overflow,
    output logic              ferr,
    input  logic              clear
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    logic rx_meta;
    logic rx_s;
    logic rx_s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        push;
    logic        expire;

`ifdef UART_RX_FRAMING_CHECK_EN
    logic        brk_wait_q, brk_wait_d;
    logic        ferr_set;
`endif

    // A load of N expires N cycles later, so a half-bit load lands mid start bit
    assign expire = (timer_q <= 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
`ifdef UART_RX_FRAMING_CHECK_EN
            brk_wait_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
`ifdef UART_RX_FRAMING_CHECK_EN
            brk_wait_q <= brk_wait_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        push       = 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
        brk_wait_d = brk_wait_q;
        ferr_set   = 1'b0;
`endif
        if (!expire) begin
            timer_d = timer_q - 32'd1;
        end

        case (state_q)
            IDLE: begin
`ifdef UART_RX_FRAMING_CHECK_EN
                if (brk_wait_q) begin
                    if (rx_s) begin
                        brk_wait_d = 1'b0;
                    end
                end else if (rx_s_d && !rx_s) begin
                    timer_d = cfg_divider >> 1;
                    state_d = START;
                end
`else
                if (rx_s_d && !rx_s) begin
                    timer_d = cfg_divider >> 1;
                    state_d = START;
                end
`endif
            end
            START: begin
                if (expire) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        timer_d   = cfg_divider;
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_d[bit_idx_q] = rx_s;
                    timer_d            = cfg_divider;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    state_d = IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
                    if (rx_s) begin
                        push = 1'b1;
                    end else begin
                        ferr_set   = 1'b1;
                        brk_wait_d = 1'b1;
                    end
`else
                    push = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents are only ever exposed through the head register
    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nx;
    logic              full, pop, wr_en, ovf_set;
    logic [DW_CNT-1:0] count_d;
    logic [7:0]        head_d;

    assign full      = (count == DW_CNT'(DEPTH));
    assign pop       = rd & valid;
    assign wr_en     = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;
    assign rd_ptr_nx = rd_ptr + AW'(1);

    always_comb begin
        count_d = count;
        if (wr_en && !pop) begin
            count_d = count + DW_CNT'(1);
        end else if (!wr_en && pop) begin
            count_d = count - DW_CNT'(1);
        end

        head_d = rd_data;
        if (wr_en && ((count == '0) || (pop && count == DW_CNT'(1)))) begin
            head_d = shreg_q;
        end else if (pop && count > DW_CNT'(1)) begin
            head_d = mem[rd_ptr_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nx;
            end
            count   <= count_d;
            valid   <= (count_d != '0);
            rd_data <= head_d;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr <= 1'b0;
        end else if (ferr_set) begin
            ferr <= 1'b1;
        end else if (clear) begin
            ferr <= 1'b0;
        end
    end
`else
    assign ferr = 1'b0;
`endif

endmodule
